// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg: op bit positions, FSM state, datapath select codes, op priority encoder.
// Latency: n/a (declarations and a pure combinational function).
// Backpressure: n/a.
package alu_iter_pkg;

    localparam int OP_MULT  = 15;
    localparam int OP_MULTU = 14;
    localparam int OP_DIV   = 13;
    localparam int OP_DIVU  = 12;
    localparam int OP_ADD   = 11;
    localparam int OP_SUB   = 10;
    localparam int OP_SLT   = 9;
    localparam int OP_SLTU  = 8;
    localparam int OP_AND   = 7;
    localparam int OP_NOR   = 6;
    localparam int OP_OR    = 5;
    localparam int OP_XOR   = 4;
    localparam int OP_SLL   = 3;
    localparam int OP_SRL   = 2;
    localparam int OP_SRA   = 1;
    localparam int OP_LUI   = 0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef enum logic [4:0] {
        SEL_NONE, SEL_MULT, SEL_MULTU, SEL_DIV, SEL_DIVU,
        SEL_ADD, SEL_SUB, SEL_SLT, SEL_SLTU, SEL_AND, SEL_NOR,
        SEL_OR, SEL_XOR, SEL_SLL, SEL_SRL, SEL_SRA, SEL_LUI
    } sel_e;

    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

    // Highest-priority set control bit wins; add outranks sub.
    function automatic sel_e op_select(input logic [15:0] ctl);
        sel_e s;
        s = SEL_NONE;
        if      (ctl[OP_MULT])  s = SEL_MULT;
        else if (ctl[OP_MULTU]) s = SEL_MULTU;
        else if (ctl[OP_DIV])   s = SEL_DIV;
        else if (ctl[OP_DIVU])  s = SEL_DIVU;
        else if (ctl[OP_ADD])   s = SEL_ADD;
        else if (ctl[OP_SUB])   s = SEL_SUB;
        else if (ctl[OP_SLT])   s = SEL_SLT;
        else if (ctl[OP_SLTU])  s = SEL_SLTU;
        else if (ctl[OP_AND])   s = SEL_AND;
        else if (ctl[OP_NOR])   s = SEL_NOR;
        else if (ctl[OP_OR])    s = SEL_OR;
        else if (ctl[OP_XOR])   s = SEL_XOR;
        else if (ctl[OP_SLL])   s = SEL_SLL;
        else if (ctl[OP_SRL])   s = SEL_SRL;
        else if (ctl[OP_SRA])   s = SEL_SRA;
        else if (ctl[OP_LUI])   s = SEL_LUI;
        return s;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: radix-2 shift-add multiply / restoring divide on magnitudes, sign fix-up on output.
// Latency: WIDTH iterations after start; done is high during the final iteration cycle.
// Backpressure: none; hi/lo hold their value until the next start. Divider built only with ALU_ITER_DIV_EN.
module alu_muldiv_iter
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mag_b_q, mag_b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic             sgn, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   add_sum;
    logic [2*WIDTH-1:0] prod, prod_neg;
`ifdef ALU_ITER_DIV_EN
    logic [WIDTH:0]   shifted, trial;
`endif

    // Operand magnitudes; only mult/div treat operands as signed.
    always_comb begin
        sgn   = (op == MD_MULT) || (op == MD_DIV);
        sa    = sgn & src_a[WIDTH-1];
        sb    = sgn & src_b[WIDTH-1];
        mag_a = sa ? -src_a : src_a;
        mag_b = sb ? -src_b : src_b;
    end

    // Per-iteration datapath: hi accumulates the partial product or the partial remainder.
    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_q} : '0);
`ifdef ALU_ITER_DIV_EN
        shifted = {hi_q, lo_q[WIDTH-1]};
        trial   = shifted - {1'b0, mag_b_q};
`endif
    end

    // Load on start, then one shift step per cycle while the counter runs.
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        mag_b_d  = mag_b_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        if (start) begin
            hi_d     = '0;
            lo_d     = mag_a;
            mag_b_d  = mag_b;
            cnt_d    = CW'(WIDTH);
`ifdef ALU_ITER_DIV_EN
            is_div_d = (op == MD_DIV) || (op == MD_DIVU);
`else
            is_div_d = 1'b0;
`endif
            neg_lo_d = sa ^ sb;
            neg_hi_d = sa;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
`ifdef ALU_ITER_DIV_EN
            if (is_div_q) begin
                if (!trial[WIDTH]) begin
                    hi_d = trial[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shifted[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else
`endif
            begin
                hi_d = add_sum[WIDTH:1];
                lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    // Iteration state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            mag_b_q  <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mag_b_q  <= mag_b_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
        end
    end

    assign done = (cnt_q == CW'(1));

    // Sign fix-up: product negated as a whole; quotient and remainder negated separately.
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_neg = -prod;
        if (is_div_q) begin
            lo = neg_lo_q ? -lo_q : lo_q;
            hi = neg_hi_q ? -hi_q : hi_q;
        end else begin
            {hi, lo} = neg_lo_q ? prod_neg : prod;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: 16-op one-hot ALU with iterative mult/multu and optional div/divu (ALU_ITER_DIV_EN).
// Latency: 1 cycle for basic ops and divide-by-zero, WIDTH+1 cycles for mul/div.
// Backpressure: result held in DONE until out_ready; a new op is taken the same cycle it is consumed.
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      alu_control,
    input  logic [WIDTH-1:0] alu_src1,
    input  logic [WIDTH-1:0] alu_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_result_hi,
    output logic             div_zero
);
    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
    logic             dz_q, dz_d, md_sel_q, md_sel_d;
    sel_e             sel_raw, sel;
    logic             is_md, is_div, div_by_zero, take, md_start, md_done;
    md_op_e           md_op;
    logic [WIDTH-1:0] md_hi, md_lo, basic_res, diff, sra_res;
    logic [WIDTH:0]   sub_ext;
    logic [SHW-1:0]   shamt;
    logic             slt_bit, sltu_bit;

    assign sel_raw = op_select(alu_control);
`ifdef ALU_ITER_DIV_EN
    assign sel = sel_raw;
`else
    assign sel = ((sel_raw == SEL_DIV) || (sel_raw == SEL_DIVU)) ? SEL_NONE : sel_raw;
`endif

    assign is_div      = (sel == SEL_DIV) || (sel == SEL_DIVU);
    assign is_md       = (sel == SEL_MULT) || (sel == SEL_MULTU) || is_div;
    assign div_by_zero = is_div && (alu_src2 == '0);

    // src1 + ~src2 + 1 gives the difference and the borrow-free carry for sltu.
    assign sub_ext  = {1'b0, alu_src1} + {1'b0, ~alu_src2} + {{WIDTH{1'b0}}, 1'b1};
    assign diff     = sub_ext[WIDTH-1:0];
    assign sltu_bit = ~sub_ext[WIDTH];
    assign slt_bit  = (alu_src1[WIDTH-1] & ~alu_src2[WIDTH-1]) |
                      (~(alu_src1[WIDTH-1] ^ alu_src2[WIDTH-1]) & diff[WIDTH-1]);
    assign shamt    = alu_src1[SHW-1:0];
    assign sra_res  = $signed(alu_src2) >>> shamt;

    // Single-cycle basic-op result.
    always_comb begin
        basic_res = '0;
        case (sel)
            SEL_ADD:  basic_res = alu_src1 + alu_src2;
            SEL_SUB:  basic_res = diff;
            SEL_SLT:  basic_res = {{(WIDTH-1){1'b0}}, slt_bit};
            SEL_SLTU: basic_res = {{(WIDTH-1){1'b0}}, sltu_bit};
            SEL_AND:  basic_res = alu_src1 & alu_src2;
            SEL_NOR:  basic_res = ~(alu_src1 | alu_src2);
            SEL_OR:   basic_res = alu_src1 | alu_src2;
            SEL_XOR:  basic_res = alu_src1 ^ alu_src2;
            SEL_SLL:  basic_res = alu_src2 << shamt;
            SEL_SRL:  basic_res = alu_src2 >> shamt;
            SEL_SRA:  basic_res = sra_res;
            SEL_LUI:  basic_res = {alu_src2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default:  basic_res = '0;
        endcase
    end

    // Map the selected op onto the iterative unit's op code.
    always_comb begin
        case (sel)
            SEL_MULTU: md_op = MD_MULTU;
            SEL_DIV:   md_op = MD_DIV;
            SEL_DIVU:  md_op = MD_DIVU;
            default:   md_op = MD_MULT;
        endcase
    end

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign md_start = in_valid && in_ready && is_md && !div_by_zero;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .op    (md_op),
        .src_a (alu_src1),
        .src_b (alu_src2),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    // FSM next state and result capture; take marks an accept in IDLE or on consume in DONE.
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        dz_d     = dz_q;
        md_sel_d = md_sel_q;
        take     = 1'b0;
        case (state_q)
            IDLE: take = in_valid;
            BUSY: if (md_done) state_d = DONE;
            DONE: if (out_ready) begin
                state_d = IDLE;
                take    = in_valid;
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            if (is_md && !div_by_zero) begin
                state_d  = BUSY;
                md_sel_d = 1'b1;
                dz_d     = 1'b0;
            end else begin
                state_d  = DONE;
                md_sel_d = 1'b0;
                dz_d     = div_by_zero;
                res_d    = div_by_zero ? '1 : basic_res;
                res_hi_d = div_by_zero ? alu_src1 : '0;
            end
        end
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            res_q    <= '0;
            res_hi_q <= '0;
            dz_q     <= 1'b0;
            md_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            dz_q     <= dz_d;
            md_sel_q <= md_sel_d;
        end
    end

    // Mul/div results come straight from the iterative unit, which holds them until its next start.
    assign out_valid     = (state_q == DONE);
    assign alu_result    = md_sel_q ? md_lo : res_q;
    assign alu_result_hi = md_sel_q ? md_hi : res_hi_q;
    assign div_zero      = dz_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed vectors against hand-computed results for alu_iter at WIDTH=32.
// Latency: measured from the accept edge to the first cycle out_valid is seen.
// Backpressure: exercises out_ready stall, same-cycle consume+accept, and reset while busy.
module tb_alu_iter;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_control;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic [31:0] alu_result_hi;
    logic        div_zero;

    int tests = 0;
    int fails = 0;

    alu_iter #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_control   (alu_control),
        .alu_src1      (alu_src1),
        .alu_src2      (alu_src2),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_result    (alu_result),
        .alu_result_hi (alu_result_hi),
        .div_zero      (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one op with out_ready high, measure latency, check results, let it be consumed.
    task automatic do_op(input string tag, input logic [15:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input logic exp_dz);
        int lat;
        check({tag, "_in_ready"}, in_ready, 1);
        alu_control = ctl;
        alu_src1    = a;
        alu_src2    = b;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        alu_control = '0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_lo"}, alu_result, exp_lo);
        check({tag, "_hi"}, alu_result_hi, exp_hi);
        check({tag, "_dz"}, div_zero, exp_dz);
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_control = '0; alu_src1 = '0; alu_src2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", alu_result, 0);
        check("rst_hi", alu_result_hi, 0);
        check("rst_dz", div_zero, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic ops
        do_op("add",  16'h0800, 32'h7FFFFFFF, 32'h00000001, 1, 32'h80000000, 0, 0);
        do_op("sub",  16'h0400, 32'd5,        32'd7,        1, 32'hFFFFFFFE, 0, 0);
        do_op("slt",  16'h0200, 32'hFFFFFFFF, 32'd1,        1, 32'd1,        0, 0);
        do_op("sltu", 16'h0100, 32'hFFFFFFFF, 32'd1,        1, 32'd0,        0, 0);
        do_op("and",  16'h0080, 32'h0000F0F0, 32'h0000FF00, 1, 32'h0000F000, 0, 0);
        do_op("nor",  16'h0040, 32'h0F0F0000, 32'h00000000, 1, 32'hF0F0FFFF, 0, 0);
        do_op("or",   16'h0020, 32'h00F00000, 32'h0000000F, 1, 32'h00F0000F, 0, 0);
        do_op("xor",  16'h0010, 32'hFF00FF00, 32'h0FF00FF0, 1, 32'hF0F0F0F0, 0, 0);
        do_op("sll",  16'h0008, 32'd31,       32'd1,        1, 32'h80000000, 0, 0);
        do_op("srl",  16'h0004, 32'd36,       32'h000000F0, 1, 32'h0000000F, 0, 0);
        do_op("sra",  16'h0002, 32'd4,        32'h80000000, 1, 32'hF8000000, 0, 0);
        do_op("lui",  16'h0001, 32'h0,        32'h1234ABCD, 1, 32'hABCD0000, 0, 0);
        do_op("none", 16'h0000, 32'h5,        32'h6,        1, 32'h0,        0, 0);
        do_op("prio_add_lui", 16'h0801, 32'd1, 32'd2,       1, 32'd3,        0, 0);

        // Multiply
        do_op("mult_neg",  16'h8000, 32'hFFFFFFFD, 32'd5,        33, 32'hFFFFFFF1, 32'hFFFFFFFF, 0);
        do_op("multu_max", 16'h4000, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000001, 32'hFFFFFFFE, 0);
        do_op("mult_pos",  16'h8000, 32'h00010000, 32'h00010000, 33, 32'h00000000, 32'h00000001, 0);
        do_op("prio_mult_add", 16'h8800, 32'd2, 32'd3,           33, 32'd6,        32'd0,        0);

        // Divide
`ifdef ALU_ITER_DIV_EN
        do_op("div_neg",  16'h2000, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
        do_op("div_min",  16'h2000, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'h00000000, 0);
        do_op("div_zero", 16'h2000, 32'd9,        32'd0,        1,  32'hFFFFFFFF, 32'd9,        1);
        do_op("divu",     16'h1000, 32'hFFFFFFFF, 32'h10,       33, 32'h0FFFFFFF, 32'h0000000F, 0);
`else
        do_op("div_off",  16'h2000, 32'hFFFFFFF9, 32'd2, 1, 32'h0, 32'h0, 0);
        do_op("div_zero_off", 16'h2000, 32'd9,    32'd0, 1, 32'h0, 32'h0, 0);
        do_op("divu_off", 16'h1000, 32'hFFFFFFFF, 32'h10, 1, 32'h0, 32'h0, 0);
`endif

        // Stall: result held while out_ready is low, then consume and accept together
        out_ready = 1'b0;
        alu_control = 16'h0800; alu_src1 = 32'd1; alu_src2 = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("stall_first_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_result", alu_result, 32'd3);
        end
        out_ready = 1'b1; in_valid = 1'b1;
        alu_control = 16'h0400; alu_src1 = 32'd10; alu_src2 = 32'd3;
        #1;
        check("b2b_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_valid", out_valid, 1);
        check("b2b_result", alu_result, 32'd7);
        @(posedge clk); #1;
        check("b2b_consumed", out_valid, 0);

        // Reset while a multiply is in flight
        alu_control = 16'h8000; alu_src1 = 32'd2; alu_src2 = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("busy_in_ready", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstb_in_ready", in_ready, 1);
        check("rstb_out_valid", out_valid, 0);
        check("rstb_result", alu_result, 0);
        check("rstb_hi", alu_result_hi, 0);
        check("rstb_dz", div_zero, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rstb_no_valid", seen, 0);
        do_op("after_rst", 16'h0800, 32'd100, 32'd23, 1, 32'd123, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
